// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side handshake and shared scratchpad read bus.
// The kernel side drives the requests through the master modport.
// The arbiter owns the grant and the read return through the slave modport.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [PTR_W-1:0]          owner;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata, owner
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one single-port scratchpad shared by NUM_REQ kernel FSMs.
// One access per cycle, 1-cycle registered read latency, optional lock that keeps
// the grant with the current owner for read-modify-write sequences (bounded by MAX_LOCK).
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic {ARB, LOCK} state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [PTR_W-1:0]    owner_q;
  logic [7:0]          lock_cnt_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic [NUM_REQ-1:0]  gnt_d;
  logic                gnt_any;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    cand_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [PTR_W-1:0]    rr_ptr_d;

  // Grant selection: owner only while locked, otherwise first request from rr_ptr upward.
  always_comb begin
    gnt_d    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = owner_q;
    cand_idx = '0;
    if (state_q == LOCK) begin
      if (bus.req[owner_q]) begin
        gnt_d[owner_q] = 1'b1;
        gnt_any        = 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!gnt_any && bus.req[cand_idx]) begin
          gnt_d[cand_idx] = 1'b1;
          gnt_any         = 1'b1;
          gnt_idx         = cand_idx;
        end
      end
    end
  end

  // Mux of the granted requester's address/data and the next round-robin start point.
  always_comb begin
    sel_addr  = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
    sel_wdata = bus.wdata[gnt_idx*DATA_W +: DATA_W];
    rr_ptr_d  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Scratchpad write port; storage is deliberately left out of reset.
  always_ff @(posedge sys_clk) begin
    if (gnt_any && bus.we[gnt_idx]) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // Arbitration FSM, lock counting and registered read return.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= '0;
      if (gnt_any && !bus.we[gnt_idx]) begin
        rvalid_q <= gnt_d;
        rdata_q  <= mem[sel_addr];
      end
      case (state_q)
        ARB: begin
          if (gnt_any) begin
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= gnt_idx;
            // The acquiring grant already counts as the first locked cycle.
            if (bus.lock[gnt_idx] && (MAX_LOCK > 1)) begin
              state_q    <= LOCK;
              lock_cnt_q <= 8'd1;
            end
          end
        end
        LOCK: begin
          if ((gnt_any && !bus.lock[owner_q]) || (lock_cnt_q == 8'(MAX_LOCK - 1))) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= ARB;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_d;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.owner  = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester operation queues drive the
// bus, a reference model predicts grants and read data, and a separate monitor
// pops expected read returns and compares them against rvalid/rdata.
module tb_mem_port_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned ML = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
    bit            known;
  } rd_t;

  op_t           opq [N][$];
  rd_t           rdq [$];
  int            gseq [$];
  logic [DW-1:0] ref_mem   [1<<AW];
  bit            ref_known [1<<AW];

  int            rr_first;
  int            lk_owner;
  int            lk_budget;
  int            m_owner;
  int            cyc;
  int            n_checks;
  int            n_errors;
  logic [DW-1:0] mon_last;
  bit            mon_known;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < N; i++) p += opq[i].size();
    return p;
  endfunction

  task automatic drive_inputs();
    logic [N-1:0]    r = '0;
    logic [N-1:0]    l = '0;
    logic [N-1:0]    w = '0;
    logic [N*AW-1:0] a = '0;
    logic [N*DW-1:0] d = '0;
    for (int i = 0; i < N; i++) begin
      if (opq[i].size() > 0) begin
        r[i]            = 1'b1;
        l[i]            = opq[i][0].lock;
        w[i]            = opq[i][0].we;
        a[i*AW +: AW]   = opq[i][0].addr;
        d[i*DW +: DW]   = opq[i][0].data;
      end
    end
    bus.req   = r;
    bus.lock  = l;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // Reference model of one cycle: who should own the port, and what that access does.
  task automatic model_eval(output logic [N-1:0] act_g);
    int         g = -1;
    logic [N-1:0] exp_g = '0;
    op_t        o;
    if (lk_owner >= 0) begin
      if (opq[lk_owner].size() > 0) g = lk_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr_first + k) % N;
        if (g < 0 && opq[j].size() > 0) g = j;
      end
    end
    if (g >= 0) exp_g[g] = 1'b1;
    chk("gnt", 64'(bus.gnt), 64'(exp_g));
    chk("owner", 64'(bus.owner), 64'(m_owner));
    act_g = bus.gnt;
    if (g >= 0) begin
      o = opq[g][0];
      if (o.we) begin
        ref_mem[o.addr]   = o.data;
        ref_known[o.addr] = 1'b1;
      end else begin
        rdq.push_back('{cyc + 1, g, ref_mem[o.addr], ref_known[o.addr]});
      end
    end
    if (lk_owner >= 0) begin
      lk_budget--;
      if ((g >= 0 && !o.lock) || lk_budget == 0) lk_owner = -1;
    end else if (g >= 0) begin
      rr_first = (g + 1) % N;
      m_owner  = g;
      if (o.lock && ML > 1) begin
        lk_owner  = g;
        lk_budget = ML - 1;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] ag;
    @(negedge sys_clk);
    model_eval(ag);
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ag[i]) begin
        gseq.push_back(i);
        if (opq[i].size() > 0) void'(opq[i].pop_front());
      end
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic model_reset();
    rdq.delete();
    gseq.delete();
    rr_first  = 0;
    lk_owner  = -1;
    lk_budget = 0;
    m_owner   = 0;
    mon_last  = '0;
    mon_known = 1'b1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < N; i++) opq[i].delete();
    model_reset();
    drive_inputs();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic run_drain(input int limit);
    int n = 0;
    while (pending() > 0 && n < limit) begin
      step();
      n++;
    end
    chk("drain_pending", 64'(pending()), 64'd0);
    for (int i = 0; i < N; i++) opq[i].delete();
    drive_inputs();
    repeat (2) step();
  endtask

  function automatic op_t mk(input logic we, input logic lk, input int unsigned a, input logic [DW-1:0] d);
    op_t o;
    o.we   = we;
    o.lock = lk;
    o.addr = AW'(a);
    o.data = d;
    return o;
  endfunction

  // Read-return monitor: each expected read lands exactly one cycle after its grant.
  always @(negedge sys_clk) begin : monitor
    rd_t          e;
    logic [N-1:0] oh;
    if (sys_rst_n) begin
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        e  = rdq.pop_front();
        oh = '0;
        oh[e.who] = 1'b1;
        chk("rvalid", 64'(bus.rvalid), 64'(oh));
        if (e.known) begin
          chk("rdata", 64'(bus.rdata), 64'(e.data));
          mon_last  = e.data;
          mon_known = 1'b1;
        end else begin
          mon_known = 1'b0;
        end
      end else begin
        chk("rvalid_idle", 64'(bus.rvalid), 64'd0);
        if (mon_known) chk("rdata_hold", 64'(bus.rdata), 64'(mon_last));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int idx;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int a = 0; a < (1 << AW); a++) ref_known[a] = 1'b0;
    do_reset();

    // 1: idle after reset
    repeat (5) step();
    chk("t1_rdata", 64'(bus.rdata), 64'd0);
    chk("t1_owner", 64'(bus.owner), 64'd0);

    // 2: write then read back through requester 0
    opq[0].push_back(mk(1'b1, 1'b0, 3, 32'h11));
    opq[0].push_back(mk(1'b0, 1'b0, 3, 32'h0));
    drive_inputs();
    run_drain(20);

    // 3: all requesters reading from reset -> strict rotation
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) opq[i].push_back(mk(1'b0, 1'b0, (i == 0) ? 3 : 16 + i, 32'h0));
    drive_inputs();
    run_drain(30);
    for (int k = 0; k < 2 * N; k++) chk("t3_order", 64'(gseq[k]), 64'(k % N));

    // 4: locked read-modify-write by requester 1 while requester 2 waits
    do_reset();
    opq[1].push_back(mk(1'b0, 1'b1, 5, 32'h0));
    opq[1].push_back(mk(1'b1, 1'b1, 6, 32'hA5A5_0006));
    opq[1].push_back(mk(1'b0, 1'b0, 6, 32'h0));
    opq[2].push_back(mk(1'b0, 1'b0, 6, 32'h0));
    drive_inputs();
    run_drain(30);
    chk("t4_seq0", 64'(gseq[0]), 64'd1);
    chk("t4_seq1", 64'(gseq[1]), 64'd1);
    chk("t4_seq2", 64'(gseq[2]), 64'd1);
    chk("t4_seq3", 64'(gseq[3]), 64'd2);

    // 5: requester 0 never lets go of the lock -> forced release after ML cycles
    do_reset();
    for (int k = 0; k < 12; k++) opq[0].push_back(mk(1'b0, (k != 11), 3, 32'h0));
    opq[3].push_back(mk(1'b0, 1'b0, 6, 32'h0));
    drive_inputs();
    run_drain(60);
    idx = -1;
    for (int k = 0; k < gseq.size(); k++) if (idx < 0 && gseq[k] == 3) idx = k;
    chk("t5_first_gnt3_pos", 64'(idx), 64'(ML));

    // randomized traffic with hazards on a small address window
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (opq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          opq[i].push_back(mk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
                              $urandom));
        end
      end
      drive_inputs();
      step();
    end
    run_drain(200);

    // 6: reset lands during a granted read; the read must not return
    opq[0].push_back(mk(1'b1, 1'b0, 8'h40, 32'hDEAD_BEEF));
    drive_inputs();
    run_drain(20);
    opq[0].push_back(mk(1'b0, 1'b0, 8'h40, 32'h0));
    drive_inputs();
    @(negedge sys_clk);
    chk("t6_gnt_before_rst", 64'(bus.gnt), 64'b0001);
    do_reset();
    repeat (3) step();
    opq[0].push_back(mk(1'b0, 1'b0, 8'h40, 32'h0));
    drive_inputs();
    run_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
